cdc_isolate_drain: RTL and testbench
====================================

# cdc_isolate_drain

Per-domain isolation and drain unit that sits directly downstream of one half of the CDC reset controller. It consumes that controller's `isolate`/`clear` requests and returns the matching `isolate_ack`/`clear_ack`. While isolation is requested it gates new bus requests, waits for all outstanding transactions to return, and then acknowledges. During the clear phase it issues a local clear pulse to the datapath it guards. One instance exists per clock domain on each side of a CDC bridge.

## Interface
Parameters:
- MAX_OUTSTANDING, 15: maximum in-flight requests tracked; range 1..255.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter (derived).
- CLEAR_CYCLES, 4: length of the `local_clear_o` pulse in cycles; range 1..255.
- TIMEOUT_CYCLES, 1024: drain timeout in cycles; used only with CDC_ISOLATE_DRAIN_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; the unit uses a single clock
- rst_i  in  1  reset, asynchronous, active-high
- isolate_i  in  1  isolation request from the reset controller's `isolate_o`
- isolate_ack_o  out  1  isolated and drained
- clear_i  in  1  clear request from the reset controller's `clear_o`
- clear_ack_o  out  1  local clear complete
- local_clear_o  out  1  synchronous clear pulse to the guarded datapath
- s_req_valid_i  in  1  upstream request valid
- s_req_ready_o  out  1  upstream request ready
- m_req_valid_o  out  1  downstream request valid
- m_req_ready_i  in  1  downstream request ready
- m_rsp_valid_i  in  1  downstream response beat (single-beat responses)
- s_rsp_valid_o  out  1  upstream response, equal to `m_rsp_valid_i`
- err_o  out  1  sticky error: response underflow, or drain timeout when the timeout feature is compiled in

## Operation
- Pass-through gating:
  - m_req_valid_o = s_req_valid_i & gate_open.
  - s_req_ready_o = m_req_ready_i & gate_open.
  - gate_open = (state==RUN) & ~isolate_i & (cnt < MAX_OUTSTANDING).
  - Gating is combinational on `isolate_i`, so no request is accepted in the cycle `isolate_i` rises.
- Outstanding counter `cnt`:
  - Increments on `m_req_valid_o & m_req_ready_i`.
  - Decrements on `m_rsp_valid_i`.
  - If both happen in the same cycle, `cnt` is unchanged.
  - Saturates at MAX_OUTSTANDING, which is the full condition and gates requests.
  - A response while `cnt==0` leaves `cnt` at 0 and sets `err_o`.
- States:
  - RUN: if isolate_i, go to DRAIN.
  - DRAIN: if ~isolate_i, go to RUN; else if cnt==0, go to ISOLATED. Responses continue to pass through.
  - ISOLATED: if ~isolate_i, go to RUN; else if clear_i, go to CLEAR.
  - CLEAR: `local_clear_o`=1. The clear counter counts CLEAR_CYCLES cycles, then goes to CLEAR_DONE. On entry, `cnt` and `err_o` are zeroed.
  - CLEAR_DONE: if ~clear_i, go to ISOLATED.
- Outputs are Moore, decoded from registered state:
  - isolate_ack_o = state ∈ {ISOLATED, CLEAR, CLEAR_DONE}.
  - clear_ack_o = (state==CLEAR_DONE).
- A `clear_i` asserted outside ISOLATED is ignored until ISOLATED is reached.
- `isolate_i` falling during CLEAR or CLEAR_DONE is ignored; isolation is held until `clear_i` falls.

## Timing
- Reset values:
  - State RUN, cnt=0, err_o=0.
  - isolate_ack_o=0, clear_ack_o=0, local_clear_o=0.
  - m_req_valid_o and s_req_ready_o follow their inputs, since the gate is open in RUN.
- `isolate_i` rises at cycle N with cnt==0: DRAIN at N+1, `isolate_ack_o`=1 at N+2.
- With cnt==k>0, `isolate_ack_o` rises 1 cycle after the cycle in which cnt reaches 0.
- `clear_i` rises at cycle M in ISOLATED:
  - `local_clear_o` is high for cycles M+1 .. M+CLEAR_CYCLES.
  - `clear_ack_o`=1 at M+CLEAR_CYCLES+1.
- `clear_i` falls at cycle P in CLEAR_DONE: `clear_ack_o`=0 at P+1; `isolate_ack_o` stays 1.
- `isolate_i` falls at cycle Q in ISOLATED: RUN at Q+1, `isolate_ack_o`=0 at Q+1, gate reopens at Q+1.
- Reset asserted mid-operation immediately forces all reset values. No drain is performed and `local_clear_o` is not pulsed.

## Configuration
- CDC_ISOLATE_DRAIN_TIMEOUT_EN defined:
  - A counter runs while in DRAIN.
  - After TIMEOUT_CYCLES cycles in DRAIN, the unit forces ISOLATED and sets `err_o`.
  - `cnt` keeps its value until the next CLEAR.
- CDC_ISOLATE_DRAIN_TIMEOUT_EN undefined: DRAIN waits indefinitely and no timeout counter is built.

## Test plan
- Reset, then 3 requests accepted with m_req_ready_i=1 and no responses -> cnt=3. Assert isolate_i -> isolate_ack_o stays 0. Return 3 responses -> isolate_ack_o=1 one cycle after cnt hits 0.
- In ISOLATED, assert clear_i at cycle M -> local_clear_o high for exactly 4 cycles (M+1..M+4), clear_ack_o=1 at M+5, cnt=0. Drop clear_i, then drop isolate_i -> acks fall and requests flow again.
- Issue 15 requests without responses -> s_req_ready_o=0 at cnt=15. Issue a request and a response in the same cycle -> cnt unchanged.
- Response at cnt=0 -> err_o=1 and cnt stays 0. A subsequent clear sequence returns err_o to 0.
- Assert rst_i in the middle of CLEAR -> all outputs take reset values within the same cycle and the state returns to RUN.
- With CDC_ISOLATE_DRAIN_TIMEOUT_EN and TIMEOUT_CYCLES=16: cnt=2 and no responses -> isolate_ack_o=1 and err_o=1 after 16 cycles in DRAIN.

Source files
------------

// File: rtl/cdc_isolate_drain.sv
// -----------------------------------------------------------------------------
// cdc_isolate_drain
//
// Purpose:
//   Per-domain isolation and drain unit placed after one half of the CDC reset
//   controller. While isolation is requested, new bus requests are gated. Once
//   all outstanding transactions have returned, isolation is acknowledged. A
//   following clear request drives a fixed-length local clear pulse into the
//   guarded datapath and is then acknowledged.
//
// Optional feature macro:
//   CDC_ISOLATE_DRAIN_TIMEOUT_EN
//     Defined   : DRAIN gives up after TIMEOUT_CYCLES, forces ISOLATED and
//                 sets err_o.
//     Undefined : DRAIN waits indefinitely and no timeout counter is built.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   isolate_i/_ack_o    isolation request / isolated-and-drained acknowledge
//   clear_i/_ack_o      clear request / local clear complete
//   local_clear_o       clear pulse to the guarded datapath (CLEAR_CYCLES long)
//   s_req_valid_i       upstream request valid
//   s_req_ready_o       upstream request ready (gated)
//   m_req_valid_o       downstream request valid (gated)
//   m_req_ready_i       downstream request ready
//   m_rsp_valid_i       downstream single-beat response
//   s_rsp_valid_o       upstream response (pass-through)
//   err_o               sticky error: response underflow or drain timeout
// -----------------------------------------------------------------------------
module cdc_isolate_drain #(
   parameter int MAX_OUTSTANDING = 15,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING+1),
   parameter int CLEAR_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic isolate_i,
   output logic isolate_ack_o,
   input  logic clear_i,
   output logic clear_ack_o,
   output logic local_clear_o,
   input  logic s_req_valid_i,
   output logic s_req_ready_o,
   output logic m_req_valid_o,
   input  logic m_req_ready_i,
   input  logic m_rsp_valid_i,
   output logic s_rsp_valid_o,
   output logic err_o
);

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_DRAIN      = 3'd1,
      ST_ISOLATED   = 3'd2,
      ST_CLEAR      = 3'd3,
      ST_CLEAR_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [7:0]       CLR_LAST = 8'(CLEAR_CYCLES-1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_clr_cnt;
   logic             r_err;
   logic             r_iso_ack;
   logic             r_clr_ack;
   logic             r_lclr;

   logic w_gate_open;
   logic w_req_fire;
   logic w_clear_entry;
   logic w_timeout;
   logic w_to_fire;

   // Gate is combinational on isolate_i so nothing slips through in the
   // cycle isolation is first requested.
   assign w_gate_open   = (r_state == ST_RUN) & ~isolate_i & (r_cnt < CNT_MAX);
   assign m_req_valid_o = s_req_valid_i & w_gate_open;
   assign s_req_ready_o = m_req_ready_i & w_gate_open;
   assign s_rsp_valid_o = m_rsp_valid_i;
   assign w_req_fire    = m_req_valid_o & m_req_ready_i;

   // Same condition the FSM uses to leave ISOLATED for CLEAR.
   assign w_clear_entry = (r_state == ST_ISOLATED) & isolate_i & clear_i;

`ifdef CDC_ISOLATE_DRAIN_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES-1);

   logic [TO_W-1:0] r_to_cnt;

   // Restarts from zero on every entry into DRAIN.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_to_cnt <= '0;
      else if (r_state != ST_DRAIN)
         r_to_cnt <= '0;
      else if (r_to_cnt != TO_LAST)
         r_to_cnt <= r_to_cnt + TO_W'(1);
   end

   assign w_timeout = (r_state == ST_DRAIN) & (r_to_cnt == TO_LAST);
`else
   // No timeout in this build; TIMEOUT_CYCLES has no effect.
   assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

   // Timeout only counts as an error when it actually forces ISOLATED.
   assign w_to_fire = w_timeout & isolate_i & (r_cnt != '0);

   // Outstanding counter and sticky error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (w_clear_entry) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_req_fire & ~m_rsp_valid_i) begin
            if (r_cnt != CNT_MAX)
               r_cnt <= r_cnt + CNT_W'(1);
         end else if (~w_req_fire & m_rsp_valid_i) begin
            if (r_cnt == '0)
               r_err <= 1'b1;
            else
               r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_to_fire)
            r_err <= 1'b1;
      end
   end

   // Control FSM; outputs are registered alongside the state they decode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_RUN;
         r_clr_cnt <= '0;
         r_iso_ack <= 1'b0;
         r_clr_ack <= 1'b0;
         r_lclr    <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (isolate_i)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (~isolate_i) begin
                  r_state <= ST_RUN;
               end else if ((r_cnt == '0) | w_timeout) begin
                  r_state   <= ST_ISOLATED;
                  r_iso_ack <= 1'b1;
               end
            end
            ST_ISOLATED: begin
               if (~isolate_i) begin
                  r_state   <= ST_RUN;
                  r_iso_ack <= 1'b0;
               end else if (clear_i) begin
                  r_state   <= ST_CLEAR;
                  r_lclr    <= 1'b1;
                  r_clr_cnt <= '0;
               end
            end
            // isolate_i is deliberately ignored here and in CLEAR_DONE.
            ST_CLEAR: begin
               if (r_clr_cnt == CLR_LAST) begin
                  r_state   <= ST_CLEAR_DONE;
                  r_lclr    <= 1'b0;
                  r_clr_ack <= 1'b1;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 8'd1;
               end
            end
            ST_CLEAR_DONE: begin
               if (~clear_i) begin
                  r_state   <= ST_ISOLATED;
                  r_clr_ack <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_RUN;
               r_iso_ack <= 1'b0;
               r_clr_ack <= 1'b0;
               r_lclr    <= 1'b0;
            end
         endcase
      end
   end

   assign isolate_ack_o = r_iso_ack;
   assign clear_ack_o   = r_clr_ack;
   assign local_clear_o = r_lclr;
   assign err_o         = r_err;

endmodule

// File: tb/tb_cdc_isolate_drain.sv
// -----------------------------------------------------------------------------
// tb_cdc_isolate_drain
//
// Self-checking bench for cdc_isolate_drain. Expected output values are pushed
// into a scoreboard queue as each cycle's stimulus is driven and are popped and
// compared when the DUT outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cdc_isolate_drain;

   localparam int MAXO = 15;
   localparam int CLRC = 4;
   localparam int TOC  = 16;

   logic clk_i = 1'b0;
   logic rst_i, isolate_i, clear_i, s_req_valid_i, m_req_ready_i, m_rsp_valid_i;
   logic isolate_ack_o, clear_ack_o, local_clear_o, s_req_ready_o;
   logic m_req_valid_o, s_rsp_valid_o, err_o;

   always #5 clk_i = ~clk_i;

   cdc_isolate_drain #(
      .MAX_OUTSTANDING (MAXO),
      .CLEAR_CYCLES    (CLRC),
      .TIMEOUT_CYCLES  (TOC)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .isolate_i     (isolate_i),
      .isolate_ack_o (isolate_ack_o),
      .clear_i       (clear_i),
      .clear_ack_o   (clear_ack_o),
      .local_clear_o (local_clear_o),
      .s_req_valid_i (s_req_valid_i),
      .s_req_ready_o (s_req_ready_o),
      .m_req_valid_o (m_req_valid_o),
      .m_req_ready_i (m_req_ready_i),
      .m_rsp_valid_i (m_rsp_valid_i),
      .s_rsp_valid_o (s_rsp_valid_o),
      .err_o         (err_o)
   );

   typedef enum int {O_ISOACK, O_CLRACK, O_LCLR, O_MVALID, O_SREADY, O_SRSP, O_ERR, O_CNT} sel_t;
   typedef struct {
      string tag;
      sel_t  sel;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input sel_t s, input int v, input string tag);
      exp_t e;
      e.tag = tag;
      e.sel = s;
      e.val = v;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] peek(input sel_t s);
      case (s)
         O_ISOACK: return {31'd0, isolate_ack_o};
         O_CLRACK: return {31'd0, clear_ack_o};
         O_LCLR:   return {31'd0, local_clear_o};
         O_MVALID: return {31'd0, m_req_valid_o};
         O_SREADY: return {31'd0, s_req_ready_o};
         O_SRSP:   return {31'd0, s_rsp_valid_o};
         O_ERR:    return {31'd0, err_o};
         default:  return 32'(dut.r_cnt);
      endcase
   endfunction

   // Sample at the falling edge, score, then move to just after the next rise.
   task automatic tick();
      exp_t e;
      @(negedge clk_i);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, peek(e.sel), e.val);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; isolate_i = 1'b0; clear_i = 1'b0;
      s_req_valid_i = 1'b1; m_req_ready_i = 1'b1; m_rsp_valid_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Reset values; gate open so valid/ready follow their inputs.
      push(O_ISOACK, 0, "rst_iso_ack"); push(O_CLRACK, 0, "rst_clr_ack");
      push(O_LCLR, 0, "rst_lclr");      push(O_ERR, 0, "rst_err");
      push(O_MVALID, 1, "rst_mvalid");  push(O_SREADY, 1, "rst_sready");
      push(O_CNT, 0, "rst_cnt");
      tick();
      s_req_valid_i = 1'b0; rst_i = 1'b0;
      tick();

      // Three requests, then isolate with responses outstanding.
      s_req_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin push(O_MVALID, 1, "t1_req"); tick(); end
      s_req_valid_i = 1'b0;
      push(O_CNT, 3, "t1_cnt3"); tick();
      isolate_i = 1'b1; s_req_valid_i = 1'b1;
      push(O_MVALID, 0, "t1_gate_mvalid"); push(O_SREADY, 0, "t1_gate_sready");
      push(O_ISOACK, 0, "t1_iso_rise_ack"); tick();
      s_req_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin push(O_ISOACK, 0, "t1_drain_ack"); tick(); end
      m_rsp_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(O_SRSP, 1, "t1_rsp_pass"); push(O_ISOACK, 0, "t1_rsp_ack"); tick();
      end
      m_rsp_valid_i = 1'b0;
      push(O_CNT, 0, "t1_cnt0"); push(O_ISOACK, 0, "t1_ack_not_yet"); tick();
      push(O_ISOACK, 1, "t1_ack"); push(O_SRSP, 0, "t1_rsp_idle"); tick();

      // Clear sequence from ISOLATED.
      clear_i = 1'b1;
      push(O_LCLR, 0, "t2_lclr_m"); push(O_CLRACK, 0, "t2_clrack_m"); tick();
      for (int i = 0; i < CLRC; i++) begin
         push(O_LCLR, 1, "t2_lclr"); push(O_CLRACK, 0, "t2_clrack_low");
         push(O_ISOACK, 1, "t2_iso_hold");
         if (i == 0) push(O_CNT, 0, "t2_cnt_clr");
         tick();
      end
      push(O_LCLR, 0, "t2_lclr_end"); push(O_CLRACK, 1, "t2_clrack"); push(O_ISOACK, 1, "t2_iso");
      tick();
      clear_i = 1'b0;
      push(O_CLRACK, 1, "t2_clrack_p"); tick();
      push(O_CLRACK, 0, "t2_clrack_fall"); push(O_ISOACK, 1, "t2_iso_stay"); tick();
      isolate_i = 1'b0; s_req_valid_i = 1'b1; m_req_ready_i = 1'b0;
      push(O_ISOACK, 1, "t2_iso_q"); push(O_MVALID, 0, "t2_gate_q"); tick();
      push(O_ISOACK, 0, "t2_iso_fall"); push(O_MVALID, 1, "t2_gate_open"); push(O_SREADY, 0, "t2_sready_nr");
      tick();
      m_req_ready_i = 1'b1;
      push(O_SREADY, 1, "t2_sready"); tick();
      s_req_valid_i = 1'b0; m_rsp_valid_i = 1'b1;
      push(O_CNT, 1, "t2_cnt1"); tick();
      m_rsp_valid_i = 1'b0;
      push(O_CNT, 0, "t2_cnt0"); push(O_ERR, 0, "t2_err"); tick();

      // Fill to MAX_OUTSTANDING, then same-cycle request and response.
      s_req_valid_i = 1'b1;
      for (int i = 0; i < MAXO; i++) begin push(O_SREADY, 1, "t3_fill"); tick(); end
      push(O_CNT, MAXO, "t3_full_cnt"); push(O_SREADY, 0, "t3_full_sready");
      push(O_MVALID, 0, "t3_full_mvalid"); tick();
      push(O_CNT, MAXO, "t3_sat_cnt");
      s_req_valid_i = 1'b0; m_rsp_valid_i = 1'b1; tick();
      s_req_valid_i = 1'b1;
      push(O_CNT, MAXO-1, "t3_cnt14"); push(O_MVALID, 1, "t3_both_mvalid"); tick();
      s_req_valid_i = 1'b0;
      push(O_CNT, MAXO-1, "t3_both_same"); tick();
      for (int i = 0; i < MAXO-2; i++) tick();
      m_rsp_valid_i = 1'b0;
      push(O_CNT, 0, "t3_cnt0"); push(O_ERR, 0, "t3_err0"); tick();

      // Underflow, then clear sequence clears the error.
      m_rsp_valid_i = 1'b1;
      push(O_SRSP, 1, "t4_rsp"); push(O_ERR, 0, "t4_err_pre"); tick();
      m_rsp_valid_i = 1'b0;
      push(O_ERR, 1, "t4_err"); push(O_CNT, 0, "t4_cnt"); tick();
      isolate_i = 1'b1; tick();
      push(O_ERR, 1, "t4_err_drain"); tick();
      push(O_ISOACK, 1, "t4_iso"); push(O_ERR, 1, "t4_err_iso"); tick();
      clear_i = 1'b1; tick();
      push(O_ERR, 0, "t4_err_clr"); push(O_LCLR, 1, "t4_lclr"); tick();
      for (int i = 0; i < CLRC-1; i++) tick();
      push(O_CLRACK, 1, "t4_clrack"); tick();
      clear_i = 1'b0; tick();
      isolate_i = 1'b0; tick();
      push(O_ISOACK, 0, "t4_iso_fall"); push(O_ERR, 0, "t4_err_run"); tick();

      // Reset in the middle of CLEAR.
      isolate_i = 1'b1; tick(); tick();
      push(O_ISOACK, 1, "t5_iso"); tick();
      clear_i = 1'b1; tick();
      push(O_LCLR, 1, "t5_lclr"); tick();
      #2;
      rst_i = 1'b1; isolate_i = 1'b0; clear_i = 1'b0; s_req_valid_i = 1'b1;
      push(O_LCLR, 0, "t5_rst_lclr"); push(O_ISOACK, 0, "t5_rst_iso");
      push(O_CLRACK, 0, "t5_rst_clrack"); push(O_ERR, 0, "t5_rst_err");
      push(O_MVALID, 1, "t5_rst_mvalid"); push(O_SREADY, 1, "t5_rst_sready");
      tick();
      rst_i = 1'b0; s_req_valid_i = 1'b0; tick();
      s_req_valid_i = 1'b1;
      push(O_MVALID, 1, "t5_run_mvalid"); push(O_ISOACK, 0, "t5_run_iso"); tick();
      s_req_valid_i = 1'b0; m_rsp_valid_i = 1'b1; tick();
      m_rsp_valid_i = 1'b0;
      push(O_CNT, 0, "t5_cnt0"); tick();

`ifdef CDC_ISOLATE_DRAIN_TIMEOUT_EN
      // Drain timeout with two responses never returned.
      s_req_valid_i = 1'b1; tick(); tick();
      s_req_valid_i = 1'b0;
      push(O_CNT, 2, "t6_cnt2"); tick();
      isolate_i = 1'b1; tick();
      for (int i = 0; i < TOC; i++) begin
         push(O_ISOACK, 0, "t6_wait_ack"); push(O_ERR, 0, "t6_wait_err"); tick();
      end
      push(O_ISOACK, 1, "t6_to_ack"); push(O_ERR, 1, "t6_to_err"); push(O_CNT, 2, "t6_cnt_kept");
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
